// File: rtl/serial_alu_pkg.sv
// Shared definitions for the serial ALU blocks: FSM state encodings and the
// default operand width.
package serial_alu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage : serial_alu_pkg

// File: rtl/_and2.sv
// Two-input AND primitive cell.
module _and2 (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a & b;

endmodule : _and2

// File: rtl/_or2.sv
// Two-input OR primitive cell.
module _or2 (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a | b;

endmodule : _or2

// File: rtl/_xor2.sv
// Two-input XOR primitive cell.
module _xor2 (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule : _xor2

// File: rtl/full_adder_cell.sv
// One-bit full adder built only from the _xor2/_and2/_or2 primitive cells.
// s = a ^ b ^ cin, cout = (a & b) | ((a ^ b) & cin).
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ab_xor_s;
  logic ab_and_s;
  logic prop_and_s;

  _xor2 u_xor_ab  (.a(a),        .b(b),   .y(ab_xor_s));
  _xor2 u_xor_sum (.a(ab_xor_s), .b(cin), .y(s));
  _and2 u_and_gen (.a(a),        .b(b),   .y(ab_and_s));
  _and2 u_and_prp (.a(ab_xor_s), .b(cin), .y(prop_and_s));
  _or2  u_or_cout (.a(ab_and_s), .b(prop_and_s), .y(cout));

endmodule : full_adder_cell

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder/subtractor: one full-adder cell plus a carry
// flop handle one bit per clock, WIDTH cycles per operation.
// Optional feature macro: SERIAL_ADDER_SUB_EN. When defined, op_sub selects
// A-B (b inverted per bit, carry-in 1); when undefined the block is add-only
// and op_sub is ignored.
module bit_serial_adder
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             accept_s;
  logic             last_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_r;
  logic [CNT_W-1:0] count_r;
  logic             carry_r;
  logic             busy_r;
  logic             done_r;
  logic             cout_r;
  logic             ovf_r;
  logic             sub_in_s;
  logic             b_bit_s;
  logic             fa_s_s;
  logic             fa_cout_s;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_r;

  assign sub_in_s = op_sub;
  assign b_bit_s  = b_sh_r[0] ^ sub_r;

  // Hold the operation select for the whole serial pass.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sub_r <= 1'b0;
    end else if (accept_s) begin
      sub_r <= op_sub;
    end else begin
      sub_r <= sub_r;
    end
  end
`else
  logic unused_op_sub_s;

  assign unused_op_sub_s = op_sub;
  assign sub_in_s        = 1'b0;
  assign b_bit_s         = b_sh_r[0];
`endif

  assign last_s = (state_r == ST_SHIFT) && (count_r == CNT_LAST);

  full_adder_cell u_fa (
    .a    (a_sh_r[0]),
    .b    (b_bit_s),
    .cin  (carry_r),
    .s    (fa_s_s),
    .cout (fa_cout_s)
  );

  // Next-state logic; start is honoured only from IDLE or DONE.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, handshake flags and the serial datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      sum_r   <= '0;
      count_r <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_SHIFT);
      done_r  <= last_s;
      if (accept_s) begin
        a_sh_r  <= a;
        b_sh_r  <= b;
        carry_r <= sub_in_s;
        count_r <= '0;
      end else if (state_r == ST_SHIFT) begin
        carry_r <= fa_cout_s;
        sum_r   <= {fa_s_s, sum_r[WIDTH-1:1]};
        a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
        b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
        count_r <= count_r + CNT_W'(1);
        if (last_s) begin
          // carry_r is the carry into the MSB at this point.
          cout_r <= fa_cout_s;
          ovf_r  <= carry_r ^ fa_cout_s;
        end else begin
          cout_r <= cout_r;
          ovf_r  <= ovf_r;
        end
      end else begin
        carry_r <= carry_r;
        count_r <= count_r;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule : bit_serial_adder

// File: tb/tb_bit_serial_adder.sv
// Directed self-checking bench for bit_serial_adder at WIDTH=8.
module tb_bit_serial_adder;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       op_sub;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int n_checks = 0;
  int n_fails  = 0;
  int lat;
  int done_seen;

  bit_serial_adder #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .op_sub  (op_sub),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start high for exactly one edge; returns at #1 after it.
  task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic sv);
    a      = av;
    b      = bv;
    op_sub = sv;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Count cycles until done is seen, bounded at 20.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) break;
    end
  endtask

  task automatic op_check(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic sv, input logic [7:0] es, input logic ec, input logic eo);
    int l;
    issue(av, bv, sv);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    a = 8'hAA; b = 8'h55; op_sub = ~sv;
    wait_done(l);
    check({tag, "_latency"}, l, 32'd8);
    check({tag, "_sum"},  {24'd0, sum}, {24'd0, es});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    check({tag, "_ovf"},  {31'd0, ovf},  {31'd0, eo});
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_sum_held"}, {24'd0, sum}, {24'd0, es});
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b1;
    a       = 8'h00;
    b       = 8'h00;
    op_sub  = 1'b0;

    // Reset held two cycles with start high: reset wins.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum",  {24'd0, sum},  32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf",  {31'd0, ovf},  32'd0);
    start   = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Plain add, wrap with signed overflow, unsigned wrap.
    op_check("add",   8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
    op_check("ovf",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op_check("wrap",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op_check("neg",   8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // Subtraction request.
`ifdef SERIAL_ADDER_SUB_EN
    op_check("sub",   8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    op_check("sub_nb", 8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0);
`else
    op_check("sub",   8'h10, 8'h20, 1'b1, 8'h30, 1'b0, 1'b0);
`endif

    // start re-pulsed mid-SHIFT is ignored.
    issue(8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_ign_busy", {31'd0, busy}, 32'd1);
    wait_done(lat);
    check("busy_ign_latency", lat, 32'd4);
    check("busy_ign_sum", {24'd0, sum}, 32'h46);

    // Back-to-back: start in the DONE cycle.
    @(posedge clk); #1;
    issue(8'h01, 8'h02, 1'b0);
    wait_done(lat);
    check("b2b_first_latency", lat, 32'd8);
    check("b2b_first_sum", {24'd0, sum}, 32'h03);
    issue(8'h50, 8'h0A, 1'b0);
    check("b2b_done_drop", {31'd0, done}, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(lat);
    check("b2b_second_latency", lat, 32'd8);
    check("b2b_second_sum", {24'd0, sum}, 32'h5A);

    // Abort at count=4, no done pulse afterwards.
    @(posedge clk); #1;
    issue(8'h0F, 8'h0F, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum",  {24'd0, sum},  32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    check("abort_ovf",  {31'd0, ovf},  32'd0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    check("abort_no_done", done_seen, 32'd0);

    // Still usable after the abort.
    op_check("post_abort", 8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_bit_serial_adder
